// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the direction-button conditioner: button bit positions,
// repeat-FSM state codes and a small sizing helper.
package btn_conditioner_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One button: 2-flop synchronizer, stability-count debounce and edge pulses.
// The *_d_o outputs expose next-state values so the parent can act on the same edge.
module btn_conditioner_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_d_o,
    output logic press_d_o,
    output logic release_d_o,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d   = s2_q;
            press_d   = s2_q;
            release_d = ~s2_q;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, debounce state and registered pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_d_o   = level_d;
    assign press_d_o   = press_d;
    assign release_d_o = release_d;
    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Direction-button conditioner: per-button debounce, auto-repeat FSM and
// opposite-pair masking producing one-cycle move strobes.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 40_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] move_pulse
);

    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] level_d_s, press_d_s, release_d_s;
    logic [N_BTN-1:0] raw_move_s, mask_s, move_d, move_q;
    logic [1:0]       state_q [N_BTN];
    logic [1:0]       state_d [N_BTN];
    logic [TW-1:0]    tmr_q   [N_BTN];
    logic [TW-1:0]    tmr_d   [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_conditioner_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
            .clk_i       (clk_100MHz),
            .rst_ni      (reset),
            .btn_i       (btn_in[g]),
            .level_d_o   (level_d_s[g]),
            .press_d_o   (press_d_s[g]),
            .release_d_o (release_d_s[g]),
            .level_o     (btn_level[g]),
            .press_o     (btn_press[g]),
            .release_o   (btn_release[g])
        );
    end

    // Auto-repeat FSM per button; a release always wins over a coincident tick.
    always_comb begin
        for (int b = 0; b < N_BTN; b++) begin
            state_d[b]    = state_q[b];
            tmr_d[b]      = tmr_q[b];
            raw_move_s[b] = 1'b0;
            case (state_q[b])
                IDLE: begin
                    if (press_d_s[b]) begin
                        state_d[b]    = DELAY;
                        tmr_d[b]      = '0;
                        raw_move_s[b] = 1'b1;
                    end else begin
                        state_d[b] = IDLE;
                    end
                end
                DELAY: begin
                    if (release_d_s[b]) begin
                        state_d[b] = IDLE;
                        tmr_d[b]   = '0;
                    end else if (tmr_q[b] == DLY_LAST) begin
                        state_d[b]    = REPEAT;
                        tmr_d[b]      = '0;
                        raw_move_s[b] = 1'b1;
                    end else begin
                        tmr_d[b] = tmr_q[b] + TW'(1);
                    end
                end
                REPEAT: begin
                    if (release_d_s[b]) begin
                        state_d[b] = IDLE;
                        tmr_d[b]   = '0;
                    end else if (tmr_q[b] == PER_LAST) begin
                        tmr_d[b]      = '0;
                        raw_move_s[b] = 1'b1;
                    end else begin
                        tmr_d[b] = tmr_q[b] + TW'(1);
                    end
                end
                default: begin
                    state_d[b] = IDLE;
                    tmr_d[b]   = '0;
                end
            endcase
        end
    end

    // Opposite directions held together cancel; uses post-update levels.
    always_comb begin
        mask_s = '0;
        if (level_d_s[BTN_U] && level_d_s[BTN_D]) begin
            mask_s[BTN_U] = 1'b1;
            mask_s[BTN_D] = 1'b1;
        end else begin
            mask_s[BTN_U] = 1'b0;
            mask_s[BTN_D] = 1'b0;
        end
        if (level_d_s[BTN_L] && level_d_s[BTN_R]) begin
            mask_s[BTN_L] = 1'b1;
            mask_s[BTN_R] = 1'b1;
        end else begin
            mask_s[BTN_L] = 1'b0;
            mask_s[BTN_R] = 1'b0;
        end
        move_d = raw_move_s & ~mask_s;
    end

    // FSM state, repeat timers and registered move strobes.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b] <= IDLE;
                tmr_q[b]   <= '0;
            end
            move_q <= '0;
        end else begin
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b] <= state_d[b];
                tmr_q[b]   <= tmr_d[b];
            end
            move_q <= move_d;
        end
    end

    assign move_pulse = move_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat parameters.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level, btn_press, btn_release, move_pulse;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(4), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .move_pulse  (move_pulse)
    );

    // rel = cycles since the accepted press; pulses at 0, 20, 28, 36, ...
    function automatic bit rep_tick(input int rel);
        return (rel == 0) || (rel >= 20 && ((rel - 20) % 8) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        reset  = 1'b0;
        btn_in = 4'hF;
        repeat (3) step();
        n_cmp++; if (btn_level !== 4'h0) begin n_err++; $display("FAIL reset_level got %h want 0", btn_level); end
        n_cmp++; if (btn_press !== 4'h0) begin n_err++; $display("FAIL reset_press got %h want 0", btn_press); end
        n_cmp++; if (btn_release !== 4'h0) begin n_err++; $display("FAIL reset_release got %h want 0", btn_release); end
        n_cmp++; if (move_pulse !== 4'h0) begin n_err++; $display("FAIL reset_move got %h want 0", move_pulse); end
        reset = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            exp_v = (s >= 6) ? 4'hF : 4'h0;
            n_cmp++; if (btn_level !== exp_v) begin n_err++; $display("FAIL held_level s=%0d got %h want %h", s, btn_level, exp_v); end
            exp_v = (s == 6) ? 4'hF : 4'h0;
            n_cmp++; if (btn_press !== exp_v) begin n_err++; $display("FAIL held_press s=%0d got %h want %h", s, btn_press, exp_v); end
            n_cmp++; if (move_pulse !== 4'h0) begin n_err++; $display("FAIL held_move_masked s=%0d got %h want 0", s, move_pulse); end
        end
        btn_in = 4'h0;
        for (int s = 1; s <= 8; s++) begin
            step();
            exp_v = (s >= 6) ? 4'h0 : 4'hF;
            n_cmp++; if (btn_level !== exp_v) begin n_err++; $display("FAIL rel_level s=%0d got %h want %h", s, btn_level, exp_v); end
            exp_v = (s == 6) ? 4'hF : 4'h0;
            n_cmp++; if (btn_release !== exp_v) begin n_err++; $display("FAIL rel_pulse s=%0d got %h want %h", s, btn_release, exp_v); end
        end
    endtask

    task automatic test_bounce();
        int first = 0;
        int cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            btn_in[0] = ~btn_in[0];
            repeat (2) begin
                step();
                n_cmp++; if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0) begin
                    n_err++; $display("FAIL bounce_quiet i=%0d got lvl=%b prs=%b want 0", i, btn_level[0], btn_press[0]);
                end
            end
        end
        btn_in[0] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (btn_press[0]) begin
                cnt++;
                if (first == 0) first = s;
            end
            n_cmp++; if (move_pulse[0] !== (s == 6)) begin n_err++; $display("FAIL bounce_move s=%0d got %b want %b", s, move_pulse[0], (s == 6)); end
        end
        n_cmp++; if (first !== 6) begin n_err++; $display("FAIL bounce_press_time got %0d want 6", first); end
        n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL bounce_press_count got %0d want 1", cnt); end
        n_cmp++; if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL bounce_level got %b want 1", btn_level[0]); end
        btn_in[0] = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_glitch();
        btn_in[1] = 1'b1;
        for (int s = 1; s <= 13; s++) begin
            if (s == 4) btn_in[1] = 1'b0;
            step();
            n_cmp++; if ({btn_level[1], btn_press[1], move_pulse[1]} !== 3'b000) begin
                n_err++; $display("FAIL glitch s=%0d got %b%b%b want 000", s, btn_level[1], btn_press[1], move_pulse[1]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [3:0] exp_v;
        btn_in[3] = 1'b1;
        for (int s = 1; s <= 85; s++) begin
            if (s == 67) btn_in[3] = 1'b0;
            step();
            exp_v = (s <= 66 && rep_tick(s - 6)) ? 4'h8 : 4'h0;
            n_cmp++; if (move_pulse !== exp_v) begin n_err++; $display("FAIL repeat_move s=%0d got %h want %h", s, move_pulse, exp_v); end
            exp_v = (s == 72) ? 4'h8 : 4'h0;
            n_cmp++; if (btn_release !== exp_v) begin n_err++; $display("FAIL repeat_release s=%0d got %h want %h", s, btn_release, exp_v); end
        end
    endtask

    task automatic test_opposite();
        logic [3:0] exp_v;
        btn_in = 4'b0111;
        for (int s = 1; s <= 64; s++) begin
            if (s == 41) btn_in[2] = 1'b0;
            step();
            exp_v    = 4'h0;
            exp_v[1] = rep_tick(s - 6);
            exp_v[0] = (s >= 46) && rep_tick(s - 6);
            n_cmp++; if (move_pulse !== exp_v) begin n_err++; $display("FAIL opposite_move s=%0d got %h want %h", s, move_pulse, exp_v); end
        end
        btn_in = 4'h0;
        repeat (10) step();
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_v;
        btn_in = 4'b1000;
        repeat (30) step();
        n_cmp++; if (btn_level !== 4'h8) begin n_err++; $display("FAIL pre_async_level got %h want 8", btn_level); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (btn_level !== 4'h0) begin n_err++; $display("FAIL async_level got %h want 0", btn_level); end
        n_cmp++; if (btn_press !== 4'h0) begin n_err++; $display("FAIL async_press got %h want 0", btn_press); end
        n_cmp++; if (btn_release !== 4'h0) begin n_err++; $display("FAIL async_release got %h want 0", btn_release); end
        n_cmp++; if (move_pulse !== 4'h0) begin n_err++; $display("FAIL async_move got %h want 0", move_pulse); end
        repeat (2) step();
        reset = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            exp_v = (s == 6) ? 4'h8 : 4'h0;
            n_cmp++; if (btn_press !== exp_v) begin n_err++; $display("FAIL rerst_press s=%0d got %h want %h", s, btn_press, exp_v); end
            exp_v = rep_tick(s - 6) ? 4'h8 : 4'h0;
            n_cmp++; if (move_pulse !== exp_v) begin n_err++; $display("FAIL rerst_move s=%0d got %h want %h", s, move_pulse, exp_v); end
        end
        btn_in = 4'h0;
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_repeat();
        test_opposite();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
